// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   FRAME_BITS / DATA_BITS : 8N1 frame geometry (start + 8 data + stop).
//   LINE_IDLE              : level of an idle serial line.
//   uart_state_e           : serializer state encoding, reused by the receiver.
package uart_pkg;

  localparam int   FRAME_BITS = 10;
  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte push handshake into the UART transmitter.
//   data  : byte offered by the producer
//   valid : data is offered this cycle
//   ready : transmitter can take a byte this cycle
// A byte moves on a rising edge with valid && ready.
//   master : producer side
//   slave  : transmitter side
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte buffer in front of the serializer.
//   clk, rst_n : clock, async active-low reset (empties the buffer)
//   push, din  : write din at the tail (caller guarantees !full)
//   full       : no free entry
//   pop, dout  : drop the head entry; dout is the head, read combinationally
//   empty      : no stored entry
// Pointers carry one extra MSB so full and empty are distinguishable
// when the index bits match.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  output logic                 full,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with an input FIFO.
//   clk, rst_n : clock, async active-low reset (abandons any frame in flight)
//   bus        : uart_tx_if.slave byte push handshake (data/valid/ready)
//   tx         : registered serial line, idles high
//   busy       : frame in progress or bytes still queued
// Parameters: CLK_PER_BIT (>= 2) cycles per bit, FIFO_DEPTH (power of two, >= 2).
// tx is registered from the current state, so the line lags the FSM by one
// cycle uniformly; every bit still lasts exactly CLK_PER_BIT cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 435,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy
);

  localparam int             CW      = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_PER_BIT - 1);

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_state_e          state;
  uart_state_e          state_n;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 tx_n;
  logic                 bit_end;

  // ready depends on registered pointers only.
  assign bus.ready = !full;
  assign push      = bus.valid && !full;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.data),
    .full  (full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty)
  );

  assign bit_end = (cnt == CNT_MAX);
  assign busy    = (state != IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= LINE_IDLE;
    end else begin
      state <= state_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = LINE_IDLE;
    unique case (state)
      IDLE: begin
        tx_n = LINE_IDLE;
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end && (bit_idx == 3'd7)) state_n = STOP;
      end
      STOP: begin
        tx_n = LINE_IDLE;
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes wait.
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit-time counter: held at 0 in IDLE so START always begins a full bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == IDLE) || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data bit index; wraps back to 0 after bit 7 as DATA ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (bit_end) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
    end else if (pop) begin
      shift <= fifo_dout;
    end else if ((state == DATA) && bit_end) begin
      shift <= {1'b0, shift[DATA_BITS-1:1]};
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter with a small input FIFO. Sits directly upstream of the `uart` receiver: it serialises bytes into 8N1 frames on a single `tx` line at the same `CLK_PER_BIT` rate the receiver expects. In loopback benches `tx` drives the receiver's `rx` pin; in the design it is the transmit half of the UART pair. Producers push bytes with a valid/ready handshake; the FIFO lets back-to-back bytes go out with no idle gap.

## Interface
- `CLK_PER_BIT`, default 435: clock cycles per bit (clock frequency / baud). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: number of input FIFO entries. Must be a power of two and ≥ 2.
- `clk` in 1: single clock; all logic is posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in 8: byte to transmit.
- `valid` in 1: `data` is offered this cycle.
- `ready` out 1: FIFO can accept a byte this cycle.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.

## Operation
- Handshake: a byte is accepted on a rising edge where `valid && ready`.
  - `ready = !full`, driven from registered FIFO state only; there is no combinational path from `valid`.
  - `valid` while `ready` is low is ignored, and the byte is dropped by the producer's choice.
- FIFO: circular buffer with read/write pointers that are `$clog2(FIFO_DEPTH)+1` bits wide. The MSB distinguishes full from empty.
  - A push while full is impossible because `ready` is low.
  - A pop while empty never occurs.
  - A simultaneous push and pop keeps the count unchanged.
- Serializer FSM: IDLE → START → DATA → STOP → (START | IDLE).
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for `CLK_PER_BIT` cycles.
  - DATA: `tx` = `shift[0]`. Shift right every `CLK_PER_BIT` cycles. After 8 bits (bit index 0..7, LSB first) go to STOP.
  - STOP: `tx` = 1 for `CLK_PER_BIT` cycles. On the last STOP cycle:
    - FIFO non-empty: pop and go to START (no idle gap).
    - FIFO empty: go to IDLE.
- Bit counter: 0..`CLK_PER_BIT-1`, width `$clog2(CLK_PER_BIT)`. It wraps to 0 on each bit boundary.
- Bit index: 3 bits.
- `tx` is registered and glitch-free.
- `busy = (state != IDLE) || !empty`.
- Reset, asynchronous and valid mid-frame:
  - State → IDLE; FIFO is emptied.
  - `tx` = 1, `ready` = 1, `busy` = 0.
  - Counters are cleared.
  - A partially sent frame is abandoned; the receiver sees it as a framing error.

## Timing
- Reset values: `tx` = 1, `ready` = 1, `busy` = 0.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM idle:
  - `busy` rises after edge N.
  - The FSM pops at edge N+1.
  - `tx` falls after edge N+2.
- Frame length: exactly `10*CLK_PER_BIT` cycles from `tx` falling to the end of the stop bit.
- Back-to-back: consecutive frames are contiguous (period `10*CLK_PER_BIT`) while the FIFO is non-empty.
- `ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- `busy` falls the cycle after the final stop bit completes with the FIFO empty.

## Structure
- Shared package `uart_pkg` holds:
  - `FRAME_BITS` = 10, `DATA_BITS` = 8.
  - `LINE_IDLE` = 1'b1.
  - The serializer state encoding (IDLE/START/DATA/STOP). The receiver reuses this encoding.
- Sub-module `uart_tx_fifo`:
  - Parameterised by `FIFO_DEPTH`.
  - Ports `push`/`din`/`full`, `pop`/`dout`/`empty`.
  - `dout` is a combinational read of the head entry.
- The top level instantiates the FIFO and contains only the FSM, the bit counter and the shift register.

## Test plan
- Loopback at `CLK_PER_BIT` = 435: push 0x55 once → `uart` receiver pulses `valid` with `data` = 0x55.
  - `tx` falls 2 cycles after acceptance.
  - Frame lasts 4350 cycles.
  - `busy` ends low.
- Waveform check: push 0x01 → `tx` is low for 435 cycles (start), high for 435 cycles (bit0), low for 7×435 cycles, then high (stop).
- Back-to-back: push 0xA5, 0x3C, 0xFF, 0x00 on consecutive cycles → receiver outputs all 4 in order.
  - Starts of successive frames are exactly 4350 cycles apart.
  - `tx` never idles between frames.
- Full FIFO: hold `valid` high with incrementing data while the first frame transmits.
  - `ready` drops after FIFO_DEPTH+1 accepts (one byte is already popped into the serializer).
  - Bytes offered while `ready` = 0 are never transmitted.
  - `ready` returns 1 cycle after the next pop.
- Reset mid-frame: assert `rst_n` = 0 during DATA bit 3 of 0xC3 with 2 bytes queued.
  - Immediately: `tx` = 1, `busy` = 0, `ready` = 1.
  - After release, push 0x5A → only 0x5A is received correctly.
- Minimum divider at `CLK_PER_BIT` = 2: push 0x96 → receiver outputs 0x96.
  - Frame lasts 20 cycles.
